// File: rtl/ip4_rtl_spa_ctl_pkg.sv
// ip4_rtl_spa_ctl_pkg: shared op classes, default latencies and latency helper for the SPA issue scheduler
package ip4_rtl_spa_ctl_pkg;
    typedef enum logic [1:0] {SPA_NRM, SPA_FP, SPA_LNG, SPA_RSV} spa_cls_e;
    localparam int LAT_NRM_DEF = 2;
    localparam int LAT_FP_DEF  = 4;
    localparam int LAT_LNG_DEF = 8;
    localparam int LNG_II_DEF  = 8;
    function automatic int max_lat(input int l_nrm, input int l_fp, input int l_lng, input bit has_fp, input bit has_lng);
        int m;
        m = l_nrm;
        if (has_fp && l_fp > m) m = l_fp;
        if (has_lng && l_lng > m) m = l_lng;
        return m;
    endfunction
endpackage

// File: rtl/ip4_rtl_spa_ctl_if.sv
// ip4_rtl_spa_ctl_if: requester, issue and write-back signals of the SPA issue scheduler
// i_req/i_req_cls/i_stall: requests, op classes, pipeline freeze; o_gnt: one-hot grant
// o_issue_*: registered issue; o_wb_*: registered retire; o_lng_busy, o_cls_err: status
interface ip4_rtl_spa_ctl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   i_req;
    logic [2*NUM_REQ-1:0] i_req_cls;
    logic                 i_stall;
    logic [NUM_REQ-1:0]   o_gnt;
    logic                 o_issue_vld;
    logic [ID_W-1:0]      o_issue_id;
    logic [1:0]           o_issue_cls;
    logic                 o_wb_vld;
    logic [ID_W-1:0]      o_wb_id;
    logic [1:0]           o_wb_cls;
    logic                 o_lng_busy;
    logic                 o_cls_err;
    modport slave (
        input  i_req, i_req_cls, i_stall,
        output o_gnt, o_issue_vld, o_issue_id, o_issue_cls, o_wb_vld, o_wb_id, o_wb_cls, o_lng_busy, o_cls_err
    );
    modport master (
        output i_req, i_req_cls, i_stall,
        input  o_gnt, o_issue_vld, o_issue_id, o_issue_cls, o_wb_vld, o_wb_id, o_wb_cls, o_lng_busy, o_cls_err
    );
endinterface

// File: rtl/ip4_rtl_rr_arb.sv
// ip4_rtl_rr_arb: N-way round-robin arbiter, one-hot grant, pointer moves to the winner when i_adv is set
// i_req: request mask; i_adv: allow pointer update; o_gnt: one-hot grant; o_id: winner index
module ip4_rtl_rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_req,
    input  logic            i_adv,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_id
);
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;
    logic            w_hit;
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N);
            if (!w_hit && i_req[w_idx]) begin
                w_hit        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = w_idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= ID_W'(N - 1);
        else if (i_adv && w_hit) r_ptr <= o_id;
    end
endmodule

// File: rtl/ip4_rtl_spa_ctl.sv
// ip4_rtl_spa_ctl: round-robin SPA issue scheduler with write-back slot reservation and long-op pacing
// clk/rst: clock, sync active-high reset; bus: requests, grant, issue, write-back and status (slave side)
module ip4_rtl_spa_ctl
    import ip4_rtl_spa_ctl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT_NRM = LAT_NRM_DEF,
    parameter int LAT_FP  = LAT_FP_DEF,
    parameter int LAT_LNG = LAT_LNG_DEF,
    parameter int LNG_II  = LNG_II_DEF,
    parameter int HAS_FP  = 1,
    parameter int HAS_LNG = 1
) (
    input logic                  clk,
    input logic                  rst,
    ip4_rtl_spa_ctl_if.slave     bus
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int MAX_LAT = max_lat(LAT_NRM, LAT_FP, LAT_LNG, HAS_FP != 0, HAS_LNG != 0);
    localparam int CNT_W   = LNG_II > 1 ? $clog2(LNG_II) : 1;
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        spa_cls_e        cls;
    } res_ent_t;
    function automatic int lat_of(input logic [1:0] c);
        return c == SPA_FP ? LAT_FP : c == SPA_LNG ? LAT_LNG : LAT_NRM;
    endfunction
    function automatic logic cls_ok(input logic [1:0] c);
        return c == SPA_NRM || (c == SPA_FP && HAS_FP != 0) || (c == SPA_LNG && HAS_LNG != 0);
    endfunction
    res_ent_t             r_res [1:MAX_LAT];
    res_ent_t             w_nxt [1:MAX_LAT];
    res_ent_t             r_iss, r_wb, w_new;
    logic [CNT_W-1:0]     r_lng_cnt;
    logic                 r_cls_err;
    logic [NUM_REQ-1:0]   w_elig, w_req, w_gnt;
    logic [ID_W-1:0]      w_gid;
    logic [1:0]           w_c, w_gcls;
    logic                 w_bad, w_free, w_adv;
    int                   w_glat;
    // A slot is free only if nothing already sits one stage behind where the new op would land,
    // which is what guarantees a single retirement per cycle.
    always_comb begin
        w_elig = '0;
        w_bad  = 1'b0;
        w_c    = '0;
        w_free = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_c    = bus.i_req_cls[2*i +: 2];
            w_free = 1'b1;
            for (int k = 1; k <= MAX_LAT; k++)
                if (k == lat_of(w_c) + 1 && r_res[k].valid) w_free = 1'b0;
            w_bad     = w_bad | (bus.i_req[i] && !cls_ok(w_c));
            w_elig[i] = bus.i_req[i] && cls_ok(w_c) && w_free && (w_c != SPA_LNG || r_lng_cnt == '0);
        end
    end
    assign w_adv = !bus.i_stall;
    assign w_req = w_elig & {NUM_REQ{w_adv && !rst}};
    ip4_rtl_rr_arb #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_adv (w_adv),
        .o_gnt (w_gnt),
        .o_id  (w_gid)
    );
    always_comb begin
        w_gcls = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_gnt[i]) w_gcls = bus.i_req_cls[2*i +: 2];
        w_new  = '{valid: |w_gnt, id: w_gid, cls: spa_cls_e'(w_gcls)};
        w_glat = lat_of(w_gcls);
        w_nxt  = '{default: '0};
        for (int k = 1; k < MAX_LAT; k++)
            w_nxt[k] = r_res[k+1];
        for (int k = 1; k <= MAX_LAT; k++)
            if (w_new.valid && k == w_glat) w_nxt[k] = w_new;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res     <= '{default: '0};
            r_iss     <= '0;
            r_wb      <= '0;
            r_lng_cnt <= '0;
            r_cls_err <= 1'b0;
        end else begin
            r_cls_err <= w_bad;
            r_iss     <= w_adv ? w_new : '0;
            if (!w_adv) r_wb.valid <= 1'b0;
            else begin
                r_wb      <= r_res[1];
                r_res     <= w_nxt;
                r_lng_cnt <= (w_new.valid && w_new.cls == SPA_LNG) ? CNT_W'(LNG_II - 1) :
                             (r_lng_cnt != '0) ? r_lng_cnt - CNT_W'(1) : r_lng_cnt;
            end
        end
    end
    assign bus.o_gnt       = w_gnt;
    assign bus.o_issue_vld = r_iss.valid;
    assign bus.o_issue_id  = r_iss.id;
    assign bus.o_issue_cls = r_iss.cls;
    assign bus.o_wb_vld    = r_wb.valid;
    assign bus.o_wb_id     = r_wb.id;
    assign bus.o_wb_cls    = r_wb.cls;
    assign bus.o_lng_busy  = r_lng_cnt != '0;
    assign bus.o_cls_err   = r_cls_err;
endmodule

// File: tb/tb_ip4_rtl_spa_ctl.sv
// tb_ip4_rtl_spa_ctl: directed and random stimulus against a retire-time schedule model of the SPA issue scheduler
module tb_ip4_rtl_spa_ctl;
    localparam int N      = 4;
    localparam int LNG_II = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ip4_rtl_spa_ctl_if #(.NUM_REQ(N)) bus ();
    ip4_rtl_spa_ctl_if #(.NUM_REQ(N)) bus_nl ();
    ip4_rtl_spa_ctl #(.NUM_REQ(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    ip4_rtl_spa_ctl #(.NUM_REQ(N), .HAS_LNG(0)) u_dut_nl (
        .clk (clk),
        .rst (rst),
        .bus (bus_nl)
    );
    int total = 0;
    int bad   = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask
    typedef struct {
        int t;
        int id;
        int cls;
    } pend_t;
    pend_t      pq[$];
    int         a_cnt, ptr, last_lng;
    logic [N-1:0] e_gnt;
    logic       e_iv, e_wv, e_err, e_busy;
    int         e_iid, e_icls, e_wid, e_wcls;
    function automatic int lat(input int c);
        return c == 1 ? 4 : c == 2 ? 8 : 2;
    endfunction
    function automatic bit taken(input int t);
        foreach (pq[q]) if (pq[q].t == t) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [2*N-1:0] cl(input int c0, input int c1, input int c2, input int c3);
        return {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
    endfunction
    // Model: every issued op is scheduled to retire at a fixed count of non-stalled cycles.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [2*N-1:0] rc, input logic st);
        int c, gid, wi, j;
        logic [N-1:0] el;
        logic bd;
        pend_t p;
        rst = r;
        bus.i_req = rq;
        bus.i_req_cls = rc;
        bus.i_stall = st;
        #1;
        e_gnt = '0;
        gid = -1;
        el = '0;
        bd = 1'b0;
        e_iv = 1'b0;
        e_wv = 1'b0;
        if (r) begin
            pq.delete();
            ptr = N - 1;
            last_lng = -1000;
            a_cnt = 0;
            e_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                c = int'(rc[2*i +: 2]);
                if (rq[i] && c == 3) bd = 1'b1;
                if (rq[i] && c != 3 && !taken(a_cnt + lat(c)) && (c != 2 || a_cnt - last_lng >= LNG_II)) el[i] = 1'b1;
            end
            if (!st)
                for (int k = 1; k <= N; k++) begin
                    j = (ptr + k) % N;
                    if (gid < 0 && el[j]) gid = j;
                end
            if (gid >= 0) e_gnt[gid] = 1'b1;
            e_err = bd;
            if (!st) begin
                wi = -1;
                foreach (pq[q]) if (pq[q].t == a_cnt) wi = q;
                if (wi >= 0) begin
                    e_wv = 1'b1;
                    e_wid = pq[wi].id;
                    e_wcls = pq[wi].cls;
                    pq.delete(wi);
                end
                if (gid >= 0) begin
                    c = int'(rc[2*gid +: 2]);
                    e_iv = 1'b1;
                    e_iid = gid;
                    e_icls = c;
                    p.t = a_cnt + lat(c);
                    p.id = gid;
                    p.cls = c;
                    pq.push_back(p);
                    ptr = gid;
                    if (c == 2) last_lng = a_cnt;
                end
                a_cnt++;
            end
        end
        e_busy = (a_cnt - last_lng) < LNG_II;
        chk("gnt", 32'(bus.o_gnt), 32'(e_gnt));
        @(posedge clk);
        #1;
        chk("issue_vld", 32'(bus.o_issue_vld), 32'(e_iv));
        if (e_iv) begin
            chk("issue_id", 32'(bus.o_issue_id), e_iid);
            chk("issue_cls", 32'(bus.o_issue_cls), e_icls);
        end
        chk("wb_vld", 32'(bus.o_wb_vld), 32'(e_wv));
        if (e_wv) begin
            chk("wb_id", 32'(bus.o_wb_id), e_wid);
            chk("wb_cls", 32'(bus.o_wb_cls), e_wcls);
        end
        chk("lng_busy", 32'(bus.o_lng_busy), 32'(e_busy));
        chk("cls_err", 32'(bus.o_cls_err), 32'(e_err));
        if (r) chk("rst_fields", 32'({bus.o_issue_id, bus.o_issue_cls, bus.o_wb_id, bus.o_wb_cls}), 0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask
    logic [N-1:0]   hreq;
    logic [2*N-1:0] hcls;
    int             rv, c;
    initial begin
        bus.i_req = '0;
        bus.i_req_cls = '0;
        bus.i_stall = 1'b0;
        bus_nl.i_req = '0;
        bus_nl.i_req_cls = '0;
        bus_nl.i_stall = 1'b0;
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        step(1'b0, 4'b0001, cl(0, 0, 0, 0), 1'b0);
        idle(4);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, cl(0, 0, 0, 0), 1'b0);
        idle(3);
        hreq = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, hreq, cl(1, 0, 0, 0), 1'b0);
            hreq = (hreq & ~e_gnt) | 4'b0010;
        end
        idle(6);
        hreq = 4'b1100;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, hreq, cl(0, 0, 2, 2), 1'b0);
            hreq = hreq & ~e_gnt;
        end
        idle(10);
        step(1'b0, 4'b0001, cl(1, 0, 0, 0), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        idle(8);
        hreq = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, hreq, cl(1, 2, 0, 0), 1'b0);
            hreq = hreq & ~e_gnt;
        end
        step(1'b1, '0, '0, 1'b0);
        idle(10);
        step(1'b0, 4'b1111, cl(0, 0, 0, 0), 1'b0);
        idle(3);
        hreq = '0;
        hcls = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!hreq[i] && $urandom_range(0, 2) == 0) begin
                    hreq[i] = 1'b1;
                    rv = int'($urandom_range(0, 19));
                    c = rv < 10 ? 0 : rv < 15 ? 1 : rv < 19 ? 2 : 3;
                    hcls[2*i +: 2] = 2'(c);
                end else if (hreq[i] && hcls[2*i +: 2] == 2'd3 && $urandom_range(0, 3) == 0) hreq[i] = 1'b0;
            end
            step($urandom_range(0, 299) == 0, hreq, hcls, $urandom_range(0, 9) == 0);
            hreq = hreq & ~e_gnt;
        end
        step(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus_nl.i_req = 4'b0010;
            bus_nl.i_req_cls = cl(0, 2, 0, 0);
            #1;
            chk("nl_gnt_lng", 32'(bus_nl.o_gnt), 0);
            step(1'b0, '0, '0, 1'b0);
            chk("nl_cls_err", 32'(bus_nl.o_cls_err), 1);
            chk("nl_issue_vld", 32'(bus_nl.o_issue_vld), 0);
        end
        bus_nl.i_req = 4'b0011;
        bus_nl.i_req_cls = cl(0, 2, 0, 0);
        #1;
        chk("nl_gnt_skip", 32'(bus_nl.o_gnt), 1);
        step(1'b0, '0, '0, 1'b0);
        chk("nl_issue_vld", 32'(bus_nl.o_issue_vld), 1);
        chk("nl_issue_id", 32'(bus_nl.o_issue_id), 0);
        chk("nl_cls_err", 32'(bus_nl.o_cls_err), 1);
        bus_nl.i_req = '0;
        bus_nl.i_req_cls = '0;
        step(1'b0, '0, '0, 1'b0);
        chk("nl_wb_early", 32'(bus_nl.o_wb_vld), 0);
        chk("nl_cls_err_clr", 32'(bus_nl.o_cls_err), 0);
        step(1'b0, '0, '0, 1'b0);
        chk("nl_wb_vld", 32'(bus_nl.o_wb_vld), 1);
        chk("nl_wb_id", 32'(bus_nl.o_wb_id), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ip4_rtl_spa_ctl.md
Name: ip4_rtl_spa_ctl

Overview:
- Issue scheduler for the ip4 stream processor array (SPA).
- Arbitrates up to NUM_REQ thread-slot requesters onto the single SPA issue port, round-robin.
- Ops have class-dependent pipeline latency. The block reserves a write-back slot at issue time, so at most one result retires per cycle.
- Sequences the non-pipelined long-op unit through an initiation-interval counter, and honours a global pipeline stall.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LAT_NRM, 2, normal-op latency, issue_vld to wb_vld, in cycles
LAT_FP, 4, floating-point op latency
LAT_LNG, 8, long-op latency
LNG_II, 8, minimum cycles between long-op issues
HAS_FP, 1, FP ops supported
HAS_LNG, 1, long ops supported
ID_W, $clog2(NUM_REQ), requester id width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  request per slot; held until granted
req_cls  in  2*NUM_REQ  op class per slot: 0 normal, 1 fp, 2 long, 3 reserved
stall  in  1  SPA pipeline freeze
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
issue_vld  out  1  registered: op issued into SPA this cycle
issue_id  out  ID_W  granted slot
issue_cls  out  2  class of issued op
wb_vld  out  1  registered: result retiring this cycle
wb_id  out  ID_W  slot owning the result
wb_cls  out  2  class of result
lng_busy  out  1  long unit inside its initiation interval
cls_err  out  1  registered pulse: a request of class 3, or of a disabled class, was present

Behaviour:
- Reset: all outputs 0. Reservation table empty, lng counter 0, RR pointer at NUM_REQ-1 so slot 0 has first priority. Reset mid-flight discards in-flight write-backs; no wb_vld after reset.
- Reservation table: res[1..MAX_LAT], MAX_LAT = max of enabled latencies. Each entry holds valid, id and cls.
- Each non-stall cycle:
  - wb_* <= res[1].
  - res[k] <= res[k+1].
  - res[L_c] <= the new grant, if any.
- Result: wb_vld rises exactly L_c cycles after the matching issue_vld.
- Eligibility of slot i with class c requires all of:
  - req[i]=1;
  - class c is enabled (class 3 is never eligible);
  - res[L_c+1] is empty, where res[MAX_LAT+1] is treated as empty;
  - for long ops, additionally lng_cnt==0.
- Arbitration:
  - Round-robin among eligible slots, searching from pointer+1 upward with wrap.
  - The pointer updates to the granted id only on a grant.
  - Ineligible requesters are skipped and do not block others.
- stall=1:
  - gnt=0.
  - Reservation table, lng counter, RR pointer and wb registers are frozen.
  - issue_vld and wb_vld are 0. A pending result appears on the first non-stall cycle after its frozen position reaches 1.
- Long counter:
  - Loaded with LNG_II-1 on a long grant.
  - Decrements on each non-stall cycle while non-zero.
  - lng_busy = (lng_cnt != 0).
- Registered issue: issue_vld/id/cls are asserted the cycle after gnt.
- cls_err: asserted the cycle after any req[i] with an illegal class. That slot is never granted.
- Simultaneous events: a grant and a retire in the same cycle are both legal. Two classes targeting the same slot cannot both win; arbitration picks one and the other re-evaluates next cycle.

Decomposition:
- Shared package ip4_rtl.svh gets:
  - enum spa_cls_e {SPA_NRM, SPA_FP, SPA_LNG, SPA_RSV};
  - the latency constants;
  - the reservation-entry struct {valid, id, cls}.
- One sub-module: ip4_rtl_rr_arb. Parameterised N-way round-robin with request mask, one-hot grant, and pointer update gated by an advance input.
- Reservation table and long counter stay inline.

Test Plan:
- Reset, then req=0001 cls normal -> gnt=0001 same cycle; issue_vld next cycle id 0; wb_vld id 0 exactly 2 cycles after issue_vld.
- req=1111, all normal, held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; one issue per cycle; wb ids in the same order, each 2 cycles later.
- Slot 0 FP (L=4) granted at cycle t; slot 1 normal (L=2) requests continuously -> slot 1 is refused at t+2 because res[3] is occupied. No cycle ever shows two retirements, and wb_id sequence matches.
- Slot 2 long granted, slot 3 long requests immediately -> lng_busy=1 for 7 cycles, slot 3 granted on the 8th cycle; each result arrives 8 cycles after its issue.
- FP issued, stall=1 for 3 cycles starting 1 cycle later -> no gnt during stall; wb_vld delayed by exactly 3 cycles (latency 4+3).
- HAS_LNG=0, slot 1 requests class 2 -> never granted, cls_err=1 next cycle. Assert rst mid-flight with 2 pending results -> no wb_vld afterwards, slot 0 granted first.
